// File: rtl/ser_pkg.sv
// Shared constants, FSM state type and the length-code helper for the serializer.
package ser_pkg;

  localparam int DATA_W  = 16;
  localparam int MOD_W   = $clog2(DATA_W);
  localparam int MIN_LEN = 3;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Length code 0 stands for a full word, so the result needs one extra bit.
  function automatic logic [MOD_W:0] mod2len(input logic [MOD_W-1:0] mod);
    if (mod == '0) return (MOD_W+1)'(DATA_W);
    return {1'b0, mod};
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: sends the top len bits of a word MSB-first,
// one bit per clock, with a valid strobe and a busy flag for back-pressure.
module serializer
  import ser_pkg::*;
(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [MOD_W-1:0]    cnt_q, cnt_d;
  logic                ser_q, ser_d;
  logic                val_q, val_d;
  logic [MOD_W:0]      len;

  assign len = mod2len(data_mod_i);

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      val_q   <= val_d;
    end
  end

  // The output registers are loaded from the next-state values, so the first
  // bit is already on the line in the cycle right after the accept.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    val_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_val_i && (len >= (MOD_W+1)'(MIN_LEN))) begin
          state_d = SHIFT;
          ser_d   = data_i[DATA_W-1];
          val_d   = 1'b1;
          shreg_d = {data_i[DATA_W-2:0], 1'b0};
          cnt_d   = MOD_W'(len - 1'b1);
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          shreg_d = '0;
        end else begin
          ser_d   = shreg_q[DATA_W-1];
          val_d   = 1'b1;
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ser_data_o     = ser_q;
  assign ser_data_val_o = val_q;
  assign busy_o         = val_q;

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter. It is the transmit-side counterpart of the 16-bit deserializer in the lab datapath.
- Accepts a DATA_W-bit word plus a length code in one cycle, then emits the selected bits MSB-first, one bit per clock, with a per-bit valid strobe.
- busy_o gives back-pressure to the upstream word source.
- A full-length word (mod = 0) yields a bit stream that the deserializer reassembles into the original 16-bit word.

Parameters:
- DATA_W, 16, parallel word width
- MOD_W, $clog2(DATA_W) = 4, width of the length code
- MIN_LEN, 3, shortest accepted burst in bits

Ports:
- clk_i  input  1  clock
- srst_i  input  1  reset; asynchronous, active-high; clock clk_i
- data_i  input  DATA_W  parallel word to transmit
- data_mod_i  input  MOD_W  number of bits to send from the MSB; 0 means DATA_W
- data_val_i  input  1  request strobe for data_i/data_mod_i
- ser_data_o  output  1  serial bit
- ser_data_val_o  output  1  ser_data_o is valid this cycle
- busy_o  output  1  serializer is transmitting; requests are ignored

Behaviour:
- Reset (async, any time, including mid-burst):
  - ser_data_o = 0, ser_data_val_o = 0, busy_o = 0.
  - FSM returns to IDLE; shift register and bit counter are cleared.
  - An interrupted burst is abandoned and not resumed.
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - A request is accepted when data_val_i = 1 and busy_o = 0.
  - len = (data_mod_i == 0) ? DATA_W : data_mod_i.
  - If len < MIN_LEN (data_mod_i = 1 or 2), the request is dropped silently and the FSM stays in IDLE. No output activity.
  - Otherwise latch data_i into the shift register, load the counter with len-1, and go to SHIFT.
- SHIFT:
  - Each cycle drives ser_data_o = shreg[DATA_W-1], ser_data_val_o = 1, busy_o = 1.
  - Each cycle the shift register shifts left by one and the counter decrements.
  - When the counter is 0 during a SHIFT cycle, that cycle carries the last bit. The next state is IDLE.
- Outputs are registered.
- Latency:
  - Accept in cycle T. Bit 0 (data_i[DATA_W-1]) appears in cycle T+1.
  - Bit k appears in cycle T+1+k. The last bit, data_i[DATA_W-len], appears in cycle T+len.
- busy_o equals ser_data_val_o: high exactly for the len bit cycles.
  - The earliest next accept is cycle T+len+1, with its first bit in T+len+2.
  - There is therefore one idle cycle between back-to-back bursts.
- data_val_i while busy_o = 1 is ignored and not queued. data_i/data_mod_i changing mid-burst has no effect.
- Outside SHIFT, ser_data_o is held at 0.
- Bits below position DATA_W-len are never emitted.
- The counter never wraps. len = DATA_W loads counter = DATA_W-1, which fits in MOD_W bits.

Decomposition:
- Package ser_pkg holds:
  - DATA_W, MOD_W, MIN_LEN constants
  - state_t enum {IDLE, SHIFT}
  - function mod2len(mod), which returns DATA_W for 0 and mod otherwise
- There is no sub-module. The block is a single module with FSM, shift register and down-counter, roughly 120-160 lines.
- The testbench reuses ser_pkg and a golden-model queue.

Test Plan:
- Full word: data_i=16'hA5C3, mod=0, val pulse at T -> ser_data_val_o high T+1..T+16. Bits are 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. busy_o mirrors valid. Outputs are 0 at T+17.
- Short word: data_i=16'hF000, mod=5 -> 5 valid bits 1,1,1,1,0 in T+1..T+5, then idle.
- Dropped lengths: mod=1 and mod=2 with val -> no ser_data_val_o/busy_o activity for 20 cycles. A subsequent mod=3, data 16'h6000 -> bits 0,1,1.
- Busy rejection: start 16'hFFFF mod=0, then pulse val with 16'h0000 at T+4 -> the stream stays all ones for 16 bits and no second burst follows.
- Back-to-back: hold val=1 with 16'h8001, mod=0 -> bursts at T+1..T+16 and T+18..T+33, with a 1-cycle gap at T+17.
- Async reset mid-burst: assert srst_i between edges at bit 7 -> all outputs 0 immediately, no further valid bits. After release, a new 16'h1234 mod=0 request serializes correctly.
- Loopback: connect to the deserializer, 1000 random 16-bit words with mod=0 -> every deser_data_o equals the word sent.
